score_counter: RTL and testbench
================================

Name: score_counter

Overview:
- Sequential producer of the BCD score digits that feed the per-digit 7-segment score displays. Each display takes a 4-bit 0–9 digit code on W.
- Counts hit/miss judgement pulses from the step-judging logic.
- Tracks a combo. A hit scores 1 point normally and 2 points once the combo reaches COMBO_THRESH.
- Applies points one unit per clock through a BCD ripple incrementer that saturates at all-9s.

Parameters:
- DIGITS, 4, number of BCD score digits.
- COMBO_THRESH, 4, combo count at or above which a hit scores 2 points.
- COMBO_W, 4, combo counter width; the counter saturates at 2^COMBO_W-1.

Ports:
- CLOCK  input  1  system clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- HIT  input  1  judged-hit level; the rising edge counts.
- MISS  input  1  judged-miss level; the rising edge counts.
- CLEAR  input  1  synchronous score clear (new song); level, acts every cycle it is high.
- SCORE  output  4*DIGITS  BCD digits. Digit i is at [4i+3:4i]; digit 0 is least significant. Each slice drives one display W input.
- COMBO  output  COMBO_W  current combo count.
- BUSY  output  1  high while points are still pending.
- SAT  output  1  score has reached all-9s and is held there.

Behaviour:
- Reset (RESET=1 at a CLOCK edge) sets SCORE=0, COMBO=0, BUSY=0, SAT=0, pending=0, hit_d=0, miss_d=0.
  - A HIT or MISS held high into the first post-reset cycle counts as a rising edge.
- Edge detection uses registered samples:
  - hit_rise = HIT & ~hit_d
  - miss_rise = MISS & ~miss_d
  - hit_d and miss_d update every cycle, including during CLEAR.
- Priority per cycle: RESET > CLEAR > miss_rise > hit_rise.
- CLEAR: SCORE=0, COMBO=0, pending=0, SAT=0, BUSY=0 on that edge. Edges in the same cycle are discarded.
- miss_rise: COMBO=0. No points. A simultaneous hit_rise is ignored.
- hit_rise:
  - pts = 2 if the pre-update COMBO >= COMBO_THRESH, else 1.
  - COMBO increments, saturating at 2^COMBO_W-1.
- pending is a 3-bit count, maximum 7.
  - pending_next = min(7, pending + pts - drain), where drain = (pending != 0).
  - Points that would overflow 7 are dropped.
- Increment: each cycle with pending != 0, SCORE gains 1 in BCD.
  - Digit 0 is incremented. A digit at 9 becomes 0 and carries into the next digit.
  - If every digit is 9 before the increment, SCORE holds and SAT is set. The pending unit is still drained and discarded.
- Latency:
  - hit_rise sampled at edge k loads pending at edge k.
  - The first point appears on SCORE after edge k+1; a second point appears after edge k+2.
- BUSY is registered and equals (pending_next != 0). It reflects pending after each edge.
- SCORE digits are always legal BCD (0–9). No A–F codes are ever output.
- SAT stays high until RESET or CLEAR.
- A reset or clear mid-drain abandons pending points immediately.

Decomposition:
- Package score_pkg:
  - DIGIT_W=4, DIGIT_MAX=4'd9
  - PTS_NORMAL=1, PTS_COMBO=2
  - PEND_W=3, PEND_MAX=7
- Sub-module bcd_digit_inc:
  - Ports: 4-bit digit in, carry in, 4-bit digit out, carry out (out=0 with carry when in=9 and carry in).
  - Instantiated DIGITS times as a ripple chain.
  - The top-level all-9s check drives SAT and suppresses the wrap.

Test Plan:
- Reset, then one HIT pulse. Expect pending=1 at edge k; SCORE=0x0001 after edge k+1; BUSY low after k+1; COMBO=1.
- Five separate HIT pulses, COMBO_THRESH=4. Pulses 1–4 each add 1. Pulse 5 (pre-COMBO=4) adds 2 over two cycles. Expect SCORE=0x0006, COMBO=5.
- Preload SCORE to 0x0099 via hits, then one HIT. Expect SCORE=0x0100 with ripple carry, and no digit ever above 9.
- Drive to 0x9999, then a HIT. Expect SCORE stays 0x9999, SAT=1, BUSY clears after 1 cycle. A following CLEAR gives SCORE=0 and SAT=0.
- COMBO=6, then HIT and MISS rising in the same cycle. Expect COMBO=0 and no points added.
- HIT held high across RESET deassertion. Expect exactly one point counted. CLEAR during BUSY (pending=2) gives SCORE=0, BUSY=0, no late increments.

Source files
------------

// File: rtl/score_pkg.sv
// Shared widths and constants for the score counter slice.
package score_pkg;
  localparam int         DIGIT_W    = 4;
  localparam logic [3:0] DIGIT_MAX  = 4'd9;
  localparam int         PTS_NORMAL = 1;
  localparam int         PTS_COMBO  = 2;
  localparam int         PEND_W     = 3;
  localparam logic [2:0] PEND_MAX   = 3'd7;
endpackage

// File: rtl/bcd_digit_inc.sv
// One BCD digit of the ripple incrementer: adds the incoming carry and
// wraps 9 -> 0 with a carry out.
module bcd_digit_inc
  import score_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  input  logic               i_carry,
  output logic [DIGIT_W-1:0] o_digit,
  output logic               o_carry
);

  // Increment by the carry, wrapping at DIGIT_MAX.
  always_comb begin
    o_digit = i_digit;
    o_carry = 1'b0;
    if (i_carry) begin
      if (i_digit == DIGIT_MAX) begin
        o_digit = '0;
        o_carry = 1'b1;
      end else begin
        o_digit = i_digit + 4'd1;
      end
    end
  end

endmodule

// File: rtl/score_counter.sv
// BCD score counter: turns hit/miss pulses into points, tracks a combo,
// and drains pending points one unit per clock into a saturating BCD score.
module score_counter #(
  parameter int DIGITS       = 4,
  parameter int COMBO_THRESH = 4,
  parameter int COMBO_W      = 4
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  HIT,
  input  logic                  MISS,
  input  logic                  CLEAR,
  output logic [4*DIGITS-1:0]   SCORE,
  output logic [COMBO_W-1:0]    COMBO,
  output logic                  BUSY,
  output logic                  SAT
);
  import score_pkg::*;

  localparam logic [COMBO_W-1:0] C_THRESH    = COMBO_W'(COMBO_THRESH);
  localparam logic [COMBO_W-1:0] C_COMBO_MAX = '1;

  logic                  r_hit_d;
  logic                  r_miss_d;
  logic [4*DIGITS-1:0]   r_score;
  logic [COMBO_W-1:0]    r_combo;
  logic [PEND_W-1:0]     r_pend;
  logic                  r_busy;
  logic                  r_sat;

  logic                  w_hit_rise;
  logic                  w_miss_rise;
  logic                  w_drain;
  logic [1:0]            w_pts;
  logic [PEND_W:0]       w_pend_sum;
  logic [PEND_W-1:0]     w_pend_next;
  logic [DIGITS:0]       w_carry;
  logic [4*DIGITS-1:0]   w_score_inc;
  logic                  w_all9;

  assign w_hit_rise  = HIT & ~r_hit_d;
  assign w_miss_rise = MISS & ~r_miss_d;
  assign w_drain     = (r_pend != '0);

  // Ripple chain always adds one; a carry out of the top digit means
  // every digit was 9, which is exactly the saturation condition.
  assign w_carry[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_inc u_digit (
      .i_digit (r_score[g*DIGIT_W +: DIGIT_W]),
      .i_carry (w_carry[g]),
      .o_digit (w_score_inc[g*DIGIT_W +: DIGIT_W]),
      .o_carry (w_carry[g+1])
    );
  end
  assign w_all9 = w_carry[DIGITS];

  // Points for this cycle and the clipped pending count; miss and clear
  // both suppress any hit in the same cycle.
  always_comb begin
    w_pts = 2'd0;
    if (!CLEAR && !w_miss_rise && w_hit_rise) begin
      w_pts = (r_combo >= C_THRESH) ? 2'(PTS_COMBO) : 2'(PTS_NORMAL);
    end
    w_pend_sum  = {1'b0, r_pend} + {2'b00, w_pts} - {3'b000, w_drain};
    w_pend_next = (w_pend_sum > {1'b0, PEND_MAX}) ? PEND_MAX
                                                   : w_pend_sum[PEND_W-1:0];
  end

  // State update: reset, then clear, then combo/pending/score progress.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_hit_d  <= 1'b0;
      r_miss_d <= 1'b0;
      r_score  <= '0;
      r_combo  <= '0;
      r_pend   <= '0;
      r_busy   <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      r_hit_d  <= HIT;
      r_miss_d <= MISS;
      if (CLEAR) begin
        r_score <= '0;
        r_combo <= '0;
        r_pend  <= '0;
        r_busy  <= 1'b0;
        r_sat   <= 1'b0;
      end else begin
        r_pend <= w_pend_next;
        r_busy <= (w_pend_next != '0);
        if (w_miss_rise) begin
          r_combo <= '0;
        end else if (w_hit_rise && (r_combo != C_COMBO_MAX)) begin
          r_combo <= r_combo + 1'b1;
        end
        if (w_drain) begin
          if (w_all9) begin
            r_sat <= 1'b1;
          end else begin
            r_score <= w_score_inc;
          end
        end
      end
    end
  end

  assign SCORE = r_score;
  assign COMBO = r_combo;
  assign BUSY  = r_busy;
  assign SAT   = r_sat;

endmodule

// File: tb/tb_score_counter.sv
// Directed bench for score_counter: latency, combo bonus, ripple carry,
// saturation, hit/miss priority, reset edge handling and clear mid-drain.
module tb_score_counter;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        HIT   = 1'b0;
  logic        MISS  = 1'b0;
  logic        CLEAR = 1'b0;
  logic [15:0] SCORE;
  logic [3:0]  COMBO;
  logic        BUSY;
  logic        SAT;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_score = 0;
  int   exp_combo = 0;
  logic bcd_bad  = 1'b0;

  score_counter #(.DIGITS(4), .COMBO_THRESH(4), .COMBO_W(4)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .HIT   (HIT),
    .MISS  (MISS),
    .CLEAR (CLEAR),
    .SCORE (SCORE),
    .COMBO (COMBO),
    .BUSY  (BUSY),
    .SAT   (SAT)
  );

  // Clock
  always #5 CLOCK = ~CLOCK;

  // Watch for any non-BCD nibble on the score output.
  always @(negedge CLOCK) begin
    for (int i = 0; i < 4; i++) begin
      if (SCORE[4*i +: 4] > 4'd9) bcd_bad = 1'b1;
    end
  end

  task automatic tick;
    @(posedge CLOCK);
    #1;
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic wait_idle(input string name);
    int guard = 0;
    while (BUSY && guard < 32) begin
      tick;
      guard++;
    end
    if (BUSY) begin
      n_checks++;
      $display("FAIL %s: BUSY still 1 after 32 cycles, required 0", name);
    end
  endtask

  // Driver tasks with a small reference model of score/combo.
  task automatic hit_pulse;
    exp_score = exp_score + ((exp_combo >= 4) ? 2 : 1);
    if (exp_score > 9999) exp_score = 9999;
    if (exp_combo < 15) exp_combo++;
    HIT = 1'b1; tick;
    HIT = 1'b0; tick;
    wait_idle("hit_drain");
  endtask

  task automatic miss_pulse;
    exp_combo = 0;
    MISS = 1'b1; tick;
    MISS = 1'b0; tick;
  endtask

  task automatic do_clear;
    CLEAR = 1'b1; tick;
    CLEAR = 1'b0;
    exp_score = 0;
    exp_combo = 0;
  endtask

  task automatic reach(input int target);
    int guard = 0;
    while (exp_score < target && guard < 20000) begin
      if ((target - exp_score) == 1 && exp_combo >= 4) miss_pulse;
      hit_pulse;
      guard++;
    end
    n_checks++;
    if (SCORE !== to_bcd(exp_score)) $display("FAIL reach_%0d: SCORE=%h required %h", target, SCORE, to_bcd(exp_score));
    else n_pass++;
  endtask

  task automatic test_reset;
    RESET = 1'b1; HIT = 1'b0; MISS = 1'b0; CLEAR = 1'b0;
    tick; tick;
    n_checks++; if (SCORE !== 16'h0000) $display("FAIL reset_score: SCORE=%h required 0000", SCORE); else n_pass++;
    n_checks++; if (COMBO !== 4'd0) $display("FAIL reset_combo: COMBO=%0d required 0", COMBO); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL reset_busy: BUSY=%b required 0", BUSY); else n_pass++;
    n_checks++; if (SAT !== 1'b0) $display("FAIL reset_sat: SAT=%b required 0", SAT); else n_pass++;
    RESET = 1'b0;
    exp_score = 0; exp_combo = 0;
  endtask

  task automatic test_single_hit;
    HIT = 1'b1; tick;
    n_checks++; if (BUSY !== 1'b1) $display("FAIL single_busy_k: BUSY=%b required 1", BUSY); else n_pass++;
    n_checks++; if (SCORE !== 16'h0000) $display("FAIL single_score_k: SCORE=%h required 0000", SCORE); else n_pass++;
    n_checks++; if (COMBO !== 4'd1) $display("FAIL single_combo: COMBO=%0d required 1", COMBO); else n_pass++;
    HIT = 1'b0; tick;
    n_checks++; if (SCORE !== 16'h0001) $display("FAIL single_score_k1: SCORE=%h required 0001", SCORE); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL single_busy_k1: BUSY=%b required 0", BUSY); else n_pass++;
    exp_score = 1; exp_combo = 1;
  endtask

  task automatic test_combo_bonus;
    do_clear;
    for (int i = 0; i < 4; i++) hit_pulse;
    n_checks++; if (SCORE !== 16'h0004) $display("FAIL combo_score4: SCORE=%h required 0004", SCORE); else n_pass++;
    HIT = 1'b1; tick;
    n_checks++; if (BUSY !== 1'b1) $display("FAIL combo_busy_k: BUSY=%b required 1", BUSY); else n_pass++;
    HIT = 1'b0; tick;
    n_checks++; if (SCORE !== 16'h0005) $display("FAIL combo_score_k1: SCORE=%h required 0005", SCORE); else n_pass++;
    n_checks++; if (BUSY !== 1'b1) $display("FAIL combo_busy_k1: BUSY=%b required 1", BUSY); else n_pass++;
    tick;
    n_checks++; if (SCORE !== 16'h0006) $display("FAIL combo_score_k2: SCORE=%h required 0006", SCORE); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL combo_busy_k2: BUSY=%b required 0", BUSY); else n_pass++;
    n_checks++; if (COMBO !== 4'd5) $display("FAIL combo_count: COMBO=%0d required 5", COMBO); else n_pass++;
    exp_score = 6; exp_combo = 5;
  endtask

  task automatic test_ripple;
    do_clear;
    reach(99);
    n_checks++; if (SCORE !== 16'h0099) $display("FAIL ripple_pre: SCORE=%h required 0099", SCORE); else n_pass++;
    hit_pulse;
    n_checks++; if (SCORE !== 16'h0100) $display("FAIL ripple_carry: SCORE=%h required 0100", SCORE); else n_pass++;
  endtask

  task automatic test_saturate;
    do_clear;
    reach(9999);
    n_checks++; if (SAT !== 1'b0) $display("FAIL sat_pre: SAT=%b required 0", SAT); else n_pass++;
    HIT = 1'b1; tick;
    n_checks++; if (BUSY !== 1'b1) $display("FAIL sat_busy_k: BUSY=%b required 1", BUSY); else n_pass++;
    HIT = 1'b0; tick;
    n_checks++; if (SCORE !== 16'h9999) $display("FAIL sat_hold: SCORE=%h required 9999", SCORE); else n_pass++;
    n_checks++; if (SAT !== 1'b1) $display("FAIL sat_set: SAT=%b required 1", SAT); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL sat_busy_k1: BUSY=%b required 0", BUSY); else n_pass++;
    tick;
    n_checks++; if (SAT !== 1'b1) $display("FAIL sat_sticky: SAT=%b required 1", SAT); else n_pass++;
    do_clear;
    n_checks++; if (SCORE !== 16'h0000) $display("FAIL sat_clear_score: SCORE=%h required 0000", SCORE); else n_pass++;
    n_checks++; if (SAT !== 1'b0) $display("FAIL sat_clear_sat: SAT=%b required 0", SAT); else n_pass++;
  endtask

  task automatic test_hit_miss_same;
    do_clear;
    for (int i = 0; i < 6; i++) hit_pulse;
    n_checks++; if (COMBO !== 4'd6) $display("FAIL hm_combo_pre: COMBO=%0d required 6", COMBO); else n_pass++;
    n_checks++; if (SCORE !== 16'h0008) $display("FAIL hm_score_pre: SCORE=%h required 0008", SCORE); else n_pass++;
    HIT = 1'b1; MISS = 1'b1; tick;
    n_checks++; if (COMBO !== 4'd0) $display("FAIL hm_combo: COMBO=%0d required 0", COMBO); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL hm_busy: BUSY=%b required 0", BUSY); else n_pass++;
    HIT = 1'b0; MISS = 1'b0; tick; tick;
    n_checks++; if (SCORE !== 16'h0008) $display("FAIL hm_score: SCORE=%h required 0008", SCORE); else n_pass++;
    exp_combo = 0;
  endtask

  task automatic test_hit_across_reset;
    HIT = 1'b1; RESET = 1'b1;
    tick; tick;
    RESET = 1'b0; tick;
    n_checks++; if (BUSY !== 1'b1) $display("FAIL rst_hit_busy: BUSY=%b required 1", BUSY); else n_pass++;
    n_checks++; if (COMBO !== 4'd1) $display("FAIL rst_hit_combo: COMBO=%0d required 1", COMBO); else n_pass++;
    tick; tick; tick;
    n_checks++; if (SCORE !== 16'h0001) $display("FAIL rst_hit_score: SCORE=%h required 0001", SCORE); else n_pass++;
    n_checks++; if (COMBO !== 4'd1) $display("FAIL rst_hit_once: COMBO=%0d required 1", COMBO); else n_pass++;
    HIT = 1'b0; tick;
    exp_score = 1; exp_combo = 1;
  endtask

  task automatic test_clear_busy;
    for (int i = 0; i < 4; i++) hit_pulse;
    n_checks++; if (SCORE !== 16'h0006) $display("FAIL clr_pre: SCORE=%h required 0006", SCORE); else n_pass++;
    HIT = 1'b1; tick;
    n_checks++; if (BUSY !== 1'b1) $display("FAIL clr_busy_pre: BUSY=%b required 1", BUSY); else n_pass++;
    HIT = 1'b0; CLEAR = 1'b1; tick;
    n_checks++; if (SCORE !== 16'h0000) $display("FAIL clr_score: SCORE=%h required 0000", SCORE); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL clr_busy: BUSY=%b required 0", BUSY); else n_pass++;
    CLEAR = 1'b0; tick; tick;
    n_checks++; if (SCORE !== 16'h0000) $display("FAIL clr_no_late: SCORE=%h required 0000", SCORE); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL clr_busy_late: BUSY=%b required 0", BUSY); else n_pass++;
    exp_score = 0; exp_combo = 0;
  endtask

  task automatic test_bcd_legal;
    n_checks++; if (bcd_bad !== 1'b0) $display("FAIL bcd_legal: non-BCD nibble seen=%b required 0", bcd_bad); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_single_hit;
    test_combo_bonus;
    test_ripple;
    test_saturate;
    test_hit_miss_same;
    test_hit_across_reset;
    test_clear_busy;
    test_bcd_legal;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
